fetch_pc_gen: RTL and testbench

- Front-end PC sequencer. It consumes the branch-resolution redirect (target PC plus taken) from the execute-stage branch unit, and it is the producer of the `pc` that the branch unit later evaluates.
- Owns the architectural fetch PC and issues one instruction-memory request at a time. It presents fetched instructions to decode with a valid/ready handshake.
- On a redirect it discards in-flight and buffered wrong-path instructions and restarts fetch at the target.
- PC is word-addressed: sequential increment is +1.

---
 rtl/fetch_pc_gen.sv | 155 +++++++++++++++
 tb/tb_fetch_pc_gen.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_gen.sv
// Purpose : front-end PC sequencer; owns the fetch PC, issues one imem request at a
//           time, presents fetched words to decode, restarts on branch redirect.
// Latency : >= 2 cycles request-to-fetch_valid (1 to issue, >= 1 memory); flush 1 cycle after redirect.
// Backpressure: no request is issued unless the output slot is free (or being drained),
//           so a response always lands in an empty slot; system_stall only gates issue.
//
// Ports:
//   clk, reset                       - clock, synchronous active-high reset
//   system_stall                     - blocks new request issue
//   redirect_valid / redirect_pc     - taken branch/jump from execute; restarts fetch
//   imem_req_valid/_ready/_addr      - instruction-memory request (word address)
//   imem_rsp_valid / imem_rsp_data   - one response per accepted request
//   fetch_valid/_ready/_pc/_instr    - instruction handed to decode
//   flush                            - registered pulse the cycle after a redirect
// Optional: define FETCH_REDIRECT_CNT_EN to add saturating redirect_cnt / drop_cnt outputs.

module fetch_pc_gen #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   system_stall,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    output logic                   imem_req_valid,
    output logic [ADDR_WIDTH-1:0]  imem_req_addr,
    input  logic                   imem_req_ready,
    input  logic                   imem_rsp_valid,
    input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
    output logic                   fetch_valid,
    input  logic                   fetch_ready,
    output logic [ADDR_WIDTH-1:0]  fetch_pc,
    output logic [INSTR_WIDTH-1:0] fetch_instr,
`ifdef FETCH_REDIRECT_CNT_EN
    output logic [31:0]            redirect_cnt,
    output logic [31:0]            drop_cnt,
`endif
    output logic                   flush
);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t                 r_state;
    logic [ADDR_WIDTH-1:0]  r_pc;
    logic [ADDR_WIDTH-1:0]  r_req_pc;
    logic                   r_fetch_valid;
    logic [ADDR_WIDTH-1:0]  r_fetch_pc;
    logic [INSTR_WIDTH-1:0] r_fetch_instr;
    logic                   r_flush;

    logic w_slot_free;
    logic w_req_valid;
    logic w_handshake;
    logic w_load;

    // Slot is free if empty or being drained by decode this very cycle.
    assign w_slot_free = !r_fetch_valid || fetch_ready;

    // A redirect suppresses issue so the stale pc_q never reaches memory.
    assign w_req_valid = !reset && (r_state == ST_REQ) && !system_stall
                         && w_slot_free && !redirect_valid;
    assign w_handshake = w_req_valid && imem_req_ready;

    // Good-path response capture; a same-cycle redirect discards it.
    assign w_load = (r_state == ST_WAIT) && imem_rsp_valid && !redirect_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_REQ;
            r_pc          <= RESET_PC;
            r_req_pc      <= RESET_PC;
            r_fetch_valid <= 1'b0;
            r_fetch_pc    <= '0;
            r_fetch_instr <= '0;
            r_flush       <= 1'b0;
        end else begin
            r_flush <= redirect_valid;
            if (redirect_valid) begin
                r_pc          <= redirect_pc;
                r_fetch_valid <= 1'b0;
                case (r_state)
                    ST_REQ:  r_state <= ST_REQ;
                    // The outstanding response is wrong-path: swallow it in DROP
                    // unless it is arriving right now.
                    ST_WAIT: r_state <= imem_rsp_valid ? ST_REQ : ST_DROP;
                    ST_DROP: r_state <= imem_rsp_valid ? ST_REQ : ST_DROP;
                    default: r_state <= ST_REQ;
                endcase
            end else begin
                if (r_fetch_valid && fetch_ready && !w_load)
                    r_fetch_valid <= 1'b0;
                case (r_state)
                    ST_REQ: begin
                        if (w_handshake) begin
                            r_state  <= ST_WAIT;
                            r_req_pc <= r_pc;
                        end
                    end
                    ST_WAIT: begin
                        if (w_load) begin
                            r_fetch_valid <= 1'b1;
                            r_fetch_instr <= imem_rsp_data;
                            r_fetch_pc    <= r_req_pc;
                            r_pc          <= r_req_pc + ADDR_WIDTH'(1);
                            r_state       <= ST_REQ;
                        end
                    end
                    ST_DROP: begin
                        if (imem_rsp_valid)
                            r_state <= ST_REQ;
                    end
                    default: r_state <= ST_REQ;
                endcase
            end
        end
    end

`ifdef FETCH_REDIRECT_CNT_EN
    logic [31:0] r_redirect_cnt;
    logic [31:0] r_drop_cnt;
    logic        w_drop;

    assign w_drop = imem_rsp_valid
                    && ((r_state == ST_DROP) || ((r_state == ST_WAIT) && redirect_valid));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_redirect_cnt <= '0;
            r_drop_cnt     <= '0;
        end else begin
            if (redirect_valid && (r_redirect_cnt != 32'hFFFF_FFFF))
                r_redirect_cnt <= r_redirect_cnt + 32'd1;
            if (w_drop && (r_drop_cnt != 32'hFFFF_FFFF))
                r_drop_cnt <= r_drop_cnt + 32'd1;
        end
    end

    assign redirect_cnt = r_redirect_cnt;
    assign drop_cnt     = r_drop_cnt;
`endif

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = r_pc;
    assign fetch_valid    = r_fetch_valid;
    assign fetch_pc       = r_fetch_pc;
    assign fetch_instr    = r_fetch_instr;
    assign flush          = r_flush;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Purpose : randomized bench for fetch_pc_gen against a transaction-level reference model.
// Latency : memory model answers 1..lat_max cycles after each accepted request.
// Backpressure: memory refuses new requests while a response is pending.

module tb_fetch_pc_gen;

    localparam int AW = 32;
    localparam int IW = 32;
    localparam logic [AW-1:0] RST_PC = '0;

    logic          clk = 1'b0;
    logic          reset;
    logic          system_stall;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          imem_req_valid;
    logic [AW-1:0] imem_req_addr;
    logic          imem_req_ready;
    logic          imem_rsp_valid;
    logic [IW-1:0] imem_rsp_data;
    logic          fetch_valid;
    logic          fetch_ready;
    logic [AW-1:0] fetch_pc;
    logic [IW-1:0] fetch_instr;
    logic          flush;
`ifdef FETCH_REDIRECT_CNT_EN
    logic [31:0]   redirect_cnt;
    logic [31:0]   drop_cnt;
`endif

    always #5 clk = ~clk;

    fetch_pc_gen #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .system_stall   (system_stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .fetch_valid    (fetch_valid),
        .fetch_ready    (fetch_ready),
        .fetch_pc       (fetch_pc),
        .fetch_instr    (fetch_instr),
`ifdef FETCH_REDIRECT_CNT_EN
        .redirect_cnt   (redirect_cnt),
        .drop_cnt       (drop_cnt),
`endif
        .flush          (flush)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Instruction memory contents: a fixed function of the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0000;
    endfunction

    // Memory environment: one pending response at a time.
    logic          mem_pend = 1'b0;
    logic [AW-1:0] mem_addr = '0;
    int            mem_lat  = 0;
    int            lat_max  = 1;

    // Reference model: architectural next PC, one outstanding fetch (possibly
    // wrong-path), the decode-side buffer and the flush pulse.
    logic          m_known = 1'b0;
    logic [AW-1:0] m_pc, m_rpc, m_fpc;
    logic [IW-1:0] m_fi;
    logic          m_busy, m_stale, m_fv, m_flush;

    task automatic step(input logic rst, input logic st, input logic rv,
                        input logic [AW-1:0] rp, input logic fr, input logic rr);
        logic exp_req;
        logic hs;
        @(posedge clk);
        #1;
        reset          = rst;
        system_stall   = st;
        redirect_valid = rv;
        redirect_pc    = rp;
        fetch_ready    = fr;
        imem_req_ready = rr & !mem_pend;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        if (mem_pend) begin
            if (mem_lat <= 1) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(mem_addr);
                mem_pend       = 1'b0;
            end else begin
                mem_lat--;
            end
        end
        @(negedge clk);
        exp_req = !rst && !m_busy && !st && (!m_fv || fr) && !rv;
        if (m_known) begin
            chk("req_vld", {31'b0, imem_req_valid}, {31'b0, exp_req});
            if (exp_req) chk("req_addr", imem_req_addr, m_pc);
            chk("fetch_vld", {31'b0, fetch_valid}, {31'b0, m_fv});
            chk("fetch_pc", fetch_pc, m_fpc);
            chk("fetch_instr", fetch_instr, m_fi);
            chk("flush", {31'b0, flush}, {31'b0, m_flush});
        end
        if (imem_req_valid && imem_req_ready) begin
            mem_pend = 1'b1;
            mem_addr = imem_req_addr;
            mem_lat  = $urandom_range(1, lat_max);
        end
        // Advance model across the coming clock edge.
        if (rst) begin
            m_known = 1'b1;
            m_pc = RST_PC; m_rpc = RST_PC; m_fpc = '0; m_fi = '0;
            m_busy = 1'b0; m_stale = 1'b0; m_fv = 1'b0; m_flush = 1'b0;
        end else begin
            hs      = exp_req && imem_req_ready;
            m_flush = rv;
            if (rv) begin
                m_pc = rp;
                m_fv = 1'b0;
                if (m_busy) begin
                    if (imem_rsp_valid) begin
                        m_busy = 1'b0; m_stale = 1'b0;
                    end else begin
                        m_stale = 1'b1;
                    end
                end
            end else begin
                if (m_fv && fr) m_fv = 1'b0;
                if (m_busy && imem_rsp_valid) begin
                    if (!m_stale) begin
                        m_fv  = 1'b1;
                        m_fpc = m_rpc;
                        m_fi  = mem_word(m_rpc);
                        m_pc  = m_rpc + 32'd1;
                    end
                    m_busy = 1'b0; m_stale = 1'b0;
                end
                if (hs) begin
                    m_busy = 1'b1;
                    m_rpc  = m_pc;
                end
            end
        end
    endtask

    initial begin
        logic found;
        reset = 1'b1; system_stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        fetch_ready = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;

        // Reset, then plain sequential fetch with 1-cycle memory.
        lat_max = 1;
        step(1, 0, 0, 0, 1, 1);
        step(1, 0, 0, 0, 1, 1);
        for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 1, 1);

        // Decode backpressure then release.
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 1);

        // Redirect to the top of the address space: wrap to 0 afterwards.
        step(0, 0, 1, 32'hFFFF_FFFF, 1, 1);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1, 1);

        // Stall and memory-not-ready holding.
        lat_max = 3;
        for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 1, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1, 1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic          rv;
            logic [AW-1:0] rp;
            rv = ($urandom_range(0, 99) < 8);
            rp = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 255));
            step(0, $urandom_range(0, 99) < 15, rv, rp,
                 $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 75);
        end

        // Reset while a request is outstanding; its response arrives after reset.
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            step(0, 0, 0, 0, 1, 1);
            found = mem_pend;
        end
        chk("wait_hs_timeout", {31'b0, found}, 32'd1);
        mem_lat = 4;
        step(1, 0, 0, 0, 1, 1);
        step(1, 0, 0, 0, 1, 1);
        for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 1, 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
